// File: rtl/fetch_chk_128_if.sv
// Observed fetch bus between traffic generator and cache.
// The master modport drives the bus; the checker only ever listens through the slave modport.
interface fetch_chk_128_if #(
  parameter int FETCH_ADDR_WIDTH = 32,
  parameter int FETCH_DATA_WIDTH = 128
);
  logic                        fetch_req_i;
  logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_i;
  logic                        fetch_gnt_i;
  logic                        fetch_rvalid_i;
  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i;

  modport master (
    output fetch_req_i, fetch_addr_i, fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i
  );
  modport slave (
    input  fetch_req_i, fetch_addr_i, fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i
  );
endinterface

// File: rtl/fetch_chk_128.sv
// Passive fetch-bus protocol/data checker: one outstanding request, data words must
// equal the line-aligned request address plus 4*word index.
module fetch_chk_128_word #(
  parameter int K = 0
) (
  input  logic [31:0] base,
  input  logic [31:0] word,
  output logic        mis
);
  assign mis = (word != base + 32'(4 * K));
endmodule

module fetch_chk_128 #(
  parameter int FETCH_ADDR_WIDTH = 32,
  parameter int FETCH_DATA_WIDTH = 128,
  parameter int N_TRANS          = 1000,
  parameter int TIMEOUT          = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chk_enable_i,
  fetch_chk_128_if.slave       bus,
  output logic [31:0]          trans_cnt_o,
  output logic [15:0]          err_cnt_o,
  output logic                 err_o,
  output logic [2:0]           first_err_o,
  output logic                 done_o
);
  localparam int NUM_LANES = FETCH_DATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, WAIT_RVALID, DONE} state_t;

  state_t                      state, nxt_state;
  logic [FETCH_ADDR_WIDTH-1:0] exp_addr;
  logic [FETCH_ADDR_WIDTH-1:0] pend_addr;
  logic                        req_pend;
  logic [31:0]                 tmo_cnt;
  logic [31:0]                 base;
  logic [NUM_LANES-1:0]        lane_mis;
  logic                        hs, rv, retire;
  logic [6:1]                  ev;
  logic [2:0]                  first_code;
  logic [16:0]                 err_sum;
  logic [32:0]                 trans_nxt;

  assign hs   = bus.fetch_req_i & bus.fetch_gnt_i;
  assign rv   = bus.fetch_rvalid_i;
  assign base = 32'(exp_addr) & 32'hFFFF_FFF0;
  assign trans_nxt = {1'b0, trans_cnt_o} + 33'd1;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fetch_chk_128_word #(.K(g)) u_word (
      .base (base),
      .word (bus.fetch_rdata_i[32*g +: 32]),
      .mis  (lane_mis[g])
    );
  end

  // Error events for this cycle; several may fire together.
  always_comb begin
    ev        = '0;
    nxt_state = state;
    retire    = 1'b0;
    if (chk_enable_i) begin
      case (state)
        IDLE: begin
          ev[2] = rv;
          if (hs) nxt_state = WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (rv) begin
            retire = 1'b1;
            ev[1]  = |lane_mis;
            if (!hs) nxt_state = (trans_nxt >= 33'(N_TRANS)) ? DONE : IDLE;
          end else if (hs) begin
            ev[3] = 1'b1;
          end else if (tmo_cnt + 32'd1 == 32'(TIMEOUT)) begin
            ev[4]     = 1'b1;
            nxt_state = IDLE;
          end
        end
        DONE: begin
          ev[2] = rv;
          ev[3] = hs;
        end
        default: nxt_state = IDLE;
      endcase
      ev[5] = hs & (|bus.fetch_addr_i[3:0]);
      ev[6] = req_pend & (~bus.fetch_req_i | (bus.fetch_addr_i != pend_addr));
    end
  end

  always_comb begin
    first_code = 3'd0;
    for (int i = 6; i >= 1; i--)
      if (ev[i]) first_code = 3'(i);
  end

  assign err_sum = {1'b0, err_cnt_o} + 17'($countones(ev));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      exp_addr    <= '0;
      pend_addr   <= '0;
      req_pend    <= 1'b0;
      tmo_cnt     <= '0;
      trans_cnt_o <= '0;
      err_cnt_o   <= '0;
      err_o       <= 1'b0;
      first_err_o <= 3'd0;
      done_o      <= 1'b0;
    end else if (chk_enable_i) begin
      state <= nxt_state;
      if (hs) begin
        exp_addr <= bus.fetch_addr_i;
        tmo_cnt  <= '0;
      end else if (state == WAIT_RVALID) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if (retire) trans_cnt_o <= trans_cnt_o + 32'd1;
      err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (|ev) err_o <= 1'b1;
      if (first_err_o == 3'd0) first_err_o <= first_code;
      if (nxt_state == DONE) done_o <= 1'b1;
      // An ungranted request must be held with a stable address next cycle.
      req_pend  <= bus.fetch_req_i & ~bus.fetch_gnt_i;
      pend_addr <= bus.fetch_addr_i;
    end
  end
endmodule
